// File: rtl/spi_burst_ram_if.sv
// SPI pin bundle for spi_burst_ram: the bus master drives SS_n/MOSI, the
// memory endpoint drives MISO and reports frame_active.
interface spi_burst_ram_if;
  logic SS_n;
  logic MOSI;
  logic MISO;
  logic frame_active;

  modport master (output SS_n, MOSI, input MISO, frame_active);
  modport slave  (input SS_n, MOSI, output MISO, frame_active);
endinterface

// File: rtl/spi_burst_ram.sv
// SPI-slave burst RAM: opcode, start address, then any number of data words
// with auto-incrementing, wrapping pointer. Optional status readback of the
// completed-write counter is built when SPI_BURST_RAM_STATUS_EN is defined.
module spi_burst_ram #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 8,
  parameter int MEM_DEPTH  = 256
) (
  input  logic          clk,
  input  logic          rst,
  spi_burst_ram_if.slave spi
);
  localparam int CNT_MAX = (ADDR_WIDTH > DATA_WIDTH) ? ADDR_WIDTH : DATA_WIDTH;
  localparam int CW      = $clog2(CNT_MAX + 1);
  localparam bit IS_POW2 = (MEM_DEPTH & (MEM_DEPTH - 1)) == 0;
`ifdef SPI_BURST_RAM_STATUS_EN
  localparam bit STATUS_EN = 1'b1;
`else
  localparam bit STATUS_EN = 1'b0;
`endif

  typedef enum logic [2:0] {IDLE, OPCODE, ADDR, WDATA, TURN, RDATA, IGNORE} state_e;

  state_e                  state_q, state_d;
  logic [1:0]              op_q, op_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0]   ptr_q, ptr_d;
  logic [ADDR_WIDTH-2:0]   addr_sh_q, addr_sh_d;
  logic [DATA_WIDTH-2:0]   sh_in_q, sh_in_d;
  logic [DATA_WIDTH-1:0]   sh_out_q, sh_out_d;
  logic                    miso_q, miso_d;

  logic [DATA_WIDTH-1:0]   mem [MEM_DEPTH];
  logic                    mem_we;
  logic [DATA_WIDTH-1:0]   mem_wdata;
  logic [ADDR_WIDTH-1:0]   ptr_inc, addr_full, addr_wrapped, rd_addr;
  logic [DATA_WIDTH-1:0]   rd_word;
  logic                    status_sel;
  logic [1:0]              op_full;
  logic                    op_ok;

  assign ptr_inc   = (ptr_q == ADDR_WIDTH'(MEM_DEPTH - 1)) ? '0 : ptr_q + ADDR_WIDTH'(1);
  assign addr_full = {addr_sh_q, spi.MOSI};
  assign mem_wdata = {sh_in_q, spi.MOSI};
  assign op_full   = {op_q[1], spi.MOSI};
  assign op_ok     = (op_full == 2'b00) || (op_full == 2'b01) || (op_full == 2'b10 && STATUS_EN);

  // Non-power-of-two depths fold an out-of-range address back by one depth.
  always_comb begin
    addr_wrapped = addr_full;
    if (IS_POW2)
      addr_wrapped = addr_full & ADDR_WIDTH'(MEM_DEPTH - 1);
    else if ({1'b0, addr_full} >= (ADDR_WIDTH + 1)'(MEM_DEPTH))
      addr_wrapped = addr_full - ADDR_WIDTH'(MEM_DEPTH);
  end

  // RDATA fetches the following word so it streams out with no gap.
  assign rd_addr = (state_q == RDATA) ? ptr_inc : ptr_q;

`ifdef SPI_BURST_RAM_STATUS_EN
  logic [DATA_WIDTH-1:0] wr_count_q, wr_count_d;
  assign status_sel = (op_q == 2'b10);
  assign rd_word    = status_sel ? wr_count_q : mem[rd_addr];
  assign wr_count_d = (mem_we && !(&wr_count_q)) ? wr_count_q + DATA_WIDTH'(1) : wr_count_q;
  always_ff @(posedge clk) begin
    if (rst) wr_count_q <= '0;
    else     wr_count_q <= wr_count_d;
  end
`else
  assign status_sel = 1'b0;
  assign rd_word    = mem[rd_addr];
`endif

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    cnt_d     = cnt_q;
    ptr_d     = ptr_q;
    addr_sh_d = addr_sh_q;
    sh_in_d   = sh_in_q;
    sh_out_d  = sh_out_q;
    miso_d    = 1'b0;
    mem_we    = 1'b0;
    if (spi.SS_n) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          op_d    = {spi.MOSI, 1'b0};
          state_d = OPCODE;
        end
        OPCODE: begin
          op_d      = op_full;
          cnt_d     = '0;
          addr_sh_d = '0;
          state_d   = op_ok ? ADDR : IGNORE;
        end
        ADDR: begin
          addr_sh_d = addr_full[ADDR_WIDTH-2:0];
          if (cnt_q == CW'(ADDR_WIDTH - 1)) begin
            cnt_d   = '0;
            sh_in_d = '0;
            state_d = (op_q == 2'b00) ? WDATA : TURN;
            if (op_q != 2'b10) ptr_d = addr_wrapped;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        WDATA: begin
          sh_in_d = mem_wdata[DATA_WIDTH-2:0];
          if (cnt_q == CW'(DATA_WIDTH - 1)) begin
            cnt_d  = '0;
            mem_we = 1'b1;
            ptr_d  = ptr_inc;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        TURN: begin
          miso_d   = rd_word[DATA_WIDTH-1];
          sh_out_d = {rd_word[DATA_WIDTH-2:0], 1'b0};
          cnt_d    = CW'(DATA_WIDTH - 1);
          state_d  = RDATA;
        end
        RDATA: begin
          if (cnt_q == '0) begin
            if (!status_sel) ptr_d = ptr_inc;
            miso_d   = rd_word[DATA_WIDTH-1];
            sh_out_d = {rd_word[DATA_WIDTH-2:0], 1'b0};
            cnt_d    = CW'(DATA_WIDTH - 1);
          end else begin
            miso_d   = sh_out_q[DATA_WIDTH-1];
            sh_out_d = {sh_out_q[DATA_WIDTH-2:0], 1'b0};
            cnt_d    = cnt_q - CW'(1);
          end
        end
        IGNORE:  state_d = IGNORE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      op_q      <= '0;
      cnt_q     <= '0;
      ptr_q     <= '0;
      addr_sh_q <= '0;
      sh_in_q   <= '0;
      sh_out_q  <= '0;
      miso_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      cnt_q     <= cnt_d;
      ptr_q     <= ptr_d;
      addr_sh_q <= addr_sh_d;
      sh_in_q   <= sh_in_d;
      sh_out_q  <= sh_out_d;
      miso_q    <= miso_d;
    end
  end

  // RAM contents survive reset; reset only blocks a coincident write.
  always_ff @(posedge clk) begin
    if (mem_we && !rst) mem[ptr_q] <= mem_wdata;
  end

  assign spi.MISO         = miso_q;
  assign spi.frame_active = (state_q != IDLE);
endmodule

// File: doc/spi_burst_ram.md
# spi_burst_ram

SPI-slave-fronted single-port RAM with burst access: one SPI frame carries an opcode, a start address and any number of data words. The address auto-increments and wraps. Data width, address width and depth are parametrised. This block is the next-generation SPI memory endpoint, sitting directly on the SPI pins and replacing the separate slave/RAM pair with an integrated burst controller.

## Interface
- `DATA_WIDTH`, default 8: RAM word width and SPI data word length in bits.
- `ADDR_WIDTH`, default 8: address field length in bits.
- `MEM_DEPTH`, default 256: number of words; must be ≤ 2^ADDR_WIDTH.
- `clk`  input  1  system clock; one SPI bit per rising edge while `SS_n`=0.
- `rst`  input  1  reset, synchronous, active-high.
- `SS_n`  input  1  frame select, active-low.
- `MOSI`  input  1  serial in, MSB first.
- `MISO`  output  1  serial out, MSB first; 0 when not driving data.
- `frame_active`  output  1  high while FSM is not IDLE.

## Operation
- Sampling: every clk edge with `SS_n`=0 samples one `MOSI` bit.
- FSM states: IDLE, OPCODE, ADDR, WDATA, TURN, RDATA, IGNORE.
- Any sample with `SS_n`=1 forces IDLE on the next state, regardless of the current state.
- IDLE → OPCODE on the first sample with `SS_n`=0. That bit is opcode[1].
- OPCODE: 2 bits total.
  - 2'b00 = WRITE_BURST.
  - 2'b01 = READ_BURST.
  - 2'b10 = READ_STATUS (see Configuration).
  - 2'b11 = reserved → IGNORE.
- ADDR: ADDR_WIDTH bits, MSB first, loaded into the address pointer `ptr`.
  - Then WRITE goes to WDATA.
  - READ/STATUS goes to TURN.
- WDATA: shifts DATA_WIDTH bits. On the last bit, mem[ptr] is written with the complete word, `ptr` increments, and WDATA repeats.
  - A partial word at frame end is discarded. No RAM write occurs.
- TURN: one cycle; MOSI is ignored. The RAM reads mem[ptr] into the shift-out register, then → RDATA.
- RDATA: drives DATA_WIDTH bits MSB first.
  - During the last bit, `ptr` increments and mem[ptr+1] is prefetched, so the next word follows with no gap.
  - MOSI is ignored.
- IGNORE: MISO=0 and no RAM access until `SS_n`=1.
- Pointer wrap: if `ptr` = MEM_DEPTH-1, it increments to 0.
  - An address loaded that is ≥ MEM_DEPTH is reduced by wrapping: `ptr` = addr − MEM_DEPTH when MEM_DEPTH is not a power of two. Otherwise the upper bits are truncated.
- Reset values:
  - State = IDLE, `ptr`=0, shift registers=0.
  - `MISO`=0, `frame_active`=0.
  - RAM contents are not reset.

## Timing
- Let cycle k be the sample of the last address bit.
- Write: the last data bit of word n is sampled at cycle k+n·DATA_WIDTH. The RAM write takes effect at the edge ending that cycle. The word is readable by a frame starting the next cycle.
- Read:
  - k+1 = TURN.
  - `MISO` carries data bit DATA_WIDTH-1 of mem[addr] during cycle k+2, registered on the k+1 edge.
  - The word ends at cycle k+1+DATA_WIDTH.
  - The next word starts at k+2+DATA_WIDTH.
- `SS_n` rising:
  - `MISO`=0 and `frame_active`=0 on the next cycle.
  - A frame may restart the cycle after IDLE is re-entered.
- `rst` asserted mid-frame: IDLE the next cycle. Any in-flight partial write is dropped. Completed words remain in RAM.
- Simultaneous `rst` and `SS_n`=0: reset wins, and no bit is sampled.

## Configuration
- `SPI_BURST_RAM_STATUS_EN` defined:
  - Opcode 2'b10 is valid. After ADDR (address ignored, `ptr` unchanged) and TURN, RDATA repeatedly shifts out `wr_count`.
  - `wr_count` is DATA_WIDTH bits: the completed write words since reset, saturating at all-ones. Reset value 0.
- `SPI_BURST_RAM_STATUS_EN` undefined: opcode 2'b10 behaves as reserved (IGNORE), and no counter is built.

## Test plan
All scenarios use DATA_WIDTH=8, ADDR_WIDTH=8, MEM_DEPTH=256.

- Write burst: 00, addr 0x10, data 0xA5, 0x3C, 0xFF → a later read burst from 0x10 returns A5, 3C, FF on MISO. First data bit at k+2, no gaps between words.
- Wrap: write 0x11, 0x22 starting at 0xFF → mem[0xFF]=0x11, mem[0x00]=0x22. A read from 0xFF returns 11, 22.
- Abort: write at addr 0x40 with data 0x5A, then `SS_n`↑ after 5 data bits → mem[0x40] unchanged. `frame_active`=0 the next cycle.
- Reserved opcode 11 followed by 20 bits → MISO stays 0, RAM unchanged, IDLE after `SS_n`↑.
- `rst` pulse during RDATA bit 3 → MISO=0 and IDLE the next cycle. A following read of the same address returns the correct word.
- Status (macro defined): 3 complete words plus 1 partial word written, then opcode 10 → MISO shifts 0x03. Macro undefined → MISO stays 0.
